// File: rtl/gray_counter_if.sv
// Control and count bus of the Gray-code up/down counter.
// The master drives the step/load controls; the counter (slave) returns the registered count.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] binary;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  modport master (
    output en, up, load, load_bin,
    input  binary, gray, wrap
  );

  modport slave (
    input  en, up, load, load_bin,
    output binary, gray, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Registered Gray-code up/down counter with synchronous load and wrap pulse.
// Binary count and its Gray code are both held in flops, updated on the same edge.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          reset,
  gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] cnt_p0;
  logic             wrap_p0;
  logic [WIDTH-1:0] cnt_p1;
  logic [WIDTH-1:0] gray_p1;
  logic             wrap_p1;

  // Stage p0: next count and wrap flag; load outranks counting
  always_comb begin
    cnt_p0  = cnt_p1;
    wrap_p0 = 1'b0;
    if (bus.load) begin
      cnt_p0 = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up) begin
        cnt_p0  = cnt_p1 + ONE;
        wrap_p0 = &cnt_p1;
      end else begin
        cnt_p0  = cnt_p1 - ONE;
        wrap_p0 = ~|cnt_p1;
      end
    end
  end

  // Stage p1: Gray code is registered from the next count, never decoded from the output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p1  <= '0;
      gray_p1 <= '0;
      wrap_p1 <= 1'b0;
    end else begin
      cnt_p1  <= cnt_p0;
      gray_p1 <= bin2gray(cnt_p0);
      wrap_p1 <= wrap_p0;
    end
  end

  assign bus.binary = cnt_p1;
  assign bus.gray   = gray_p1;
  assign bus.wrap   = wrap_p1;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: directed WIDTH=4 vectors and a WIDTH=8 random run.
module tb_gray_counter;

  logic clk = 1'b0;
  logic reset4;
  logic reset8;

  always #5 clk = ~clk;

  gray_counter_if #(.WIDTH(4)) if4 ();
  gray_counter_if #(.WIDTH(8)) if8 ();

  gray_counter #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset4), .bus(if4.slave));
  gray_counter #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset8), .bus(if8.slave));

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic       w;
    bit         onebit;
  } exp4_t;

  typedef struct {
    logic [7:0] b;
    logic [7:0] g;
    logic       w;
  } exp8_t;

  exp4_t q4[$];
  exp8_t q8[$];

  int n_checks = 0;
  int n_pass   = 0;
  int model_wraps8 = 0;
  int dut_wraps8   = 0;
  logic [3:0] prev_gray4 = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (q4.size() > 0) begin
      exp4_t e;
      e = q4.pop_front();
      check("dut4_outputs", {23'd0, if4.binary, if4.gray, if4.wrap}, {23'd0, e.b, e.g, e.w});
      if (e.onebit)
        check("dut4_one_bit_step", $countones(prev_gray4 ^ if4.gray), 32'd1);
      prev_gray4 = if4.gray;
    end
    if (q8.size() > 0) begin
      exp8_t e8;
      e8 = q8.pop_front();
      check("dut8_outputs", {15'd0, if8.binary, if8.gray, if8.wrap}, {15'd0, e8.b, e8.g, e8.w});
      check("dut8_gray_invariant", {24'd0, if8.gray}, {24'd0, if8.binary ^ (if8.binary >> 1)});
      if (if8.wrap) dut_wraps8++;
    end
  end

  task automatic step4(input logic en, input logic up, input logic ld, input logic [3:0] lb,
                       input logic [3:0] eb, input logic [3:0] eg, input logic ew, input bit ob);
    @(negedge clk);
    #1;
    if4.en = en; if4.up = up; if4.load = ld; if4.load_bin = lb;
    @(posedge clk);
    q4.push_back('{b: eb, g: eg, w: ew, onebit: ob});
  endtask

  task automatic check_now4(input string name, input logic [3:0] eb, input logic [3:0] eg, input logic ew);
    check(name, {23'd0, if4.binary, if4.gray, if4.wrap}, {23'd0, eb, eg, ew});
  endtask

  // Gray codes after each of 16 up-steps from 0 (binary 1..15 then 0)
  logic [3:0] up_gray [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [3:0] up5_gray [5] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset4 = 1'b1; reset8 = 1'b1;
    if4.en = 0; if4.up = 0; if4.load = 0; if4.load_bin = '0;
    if8.en = 0; if8.up = 0; if8.load = 0; if8.load_bin = '0;
    repeat (2) @(negedge clk);
    check_now4("reset_state", 4'h0, 4'h0, 1'b0);
    #1 reset4 = 1'b0;

    // Count up to 5, then assert reset asynchronously mid-cycle
    for (int i = 0; i < 5; i++)
      step4(1, 1, 0, 4'h0, 4'(i + 1), up5_gray[i], 1'b0, i != 0);
    @(negedge clk);
    #1;
    if4.en = 1; if4.up = 1;
    reset4 = 1'b1;
    #1 check_now4("async_reset_immediate", 4'h0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    check_now4("reset_held", 4'h0, 4'h0, 1'b0);
    #1 reset4 = 1'b0; if4.en = 0;

    // Full up-count with wrap, then one more step
    for (int i = 0; i < 16; i++)
      step4(1, 1, 0, 4'h0, 4'(i + 1), up_gray[i], i == 15, i != 0);
    step4(1, 1, 0, 4'h0, 4'h1, 4'h1, 1'b0, 1'b1);

    // Down-count wrap from 0
    step4(0, 0, 1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step4(1, 0, 0, 4'h0, 4'hF, 4'h8, 1'b1, 1'b1);
    step4(1, 0, 0, 4'h0, 4'hE, 4'h9, 1'b0, 1'b1);

    // Load beats enable
    step4(1, 1, 1, 4'hA, 4'hA, 4'hF, 1'b0, 1'b0);
    step4(1, 1, 0, 4'h0, 4'hB, 4'hE, 1'b0, 1'b1);

    // Loading the wrap target never raises wrap; the following step does
    step4(1, 1, 1, 4'hF, 4'hF, 4'h8, 1'b0, 1'b0);
    step4(1, 1, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);

    // Hold, then direction changes
    step4(0, 0, 1, 4'h6, 4'h6, 4'h5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step4(0, i[0], 0, 4'h3, 4'h6, 4'h5, 1'b0, 1'b0);
    step4(1, 1, 0, 4'h0, 4'h7, 4'h4, 1'b0, 1'b1);
    step4(1, 0, 0, 4'h0, 4'h6, 4'h5, 1'b0, 1'b1);
    step4(1, 1, 0, 4'h0, 4'h7, 4'h4, 1'b0, 1'b1);
    @(negedge clk);
    #1 if4.en = 0;

    // WIDTH=8 random run against a reference model
    begin
      logic [7:0] mc;
      logic       mw;
      mc = 8'h00;
      for (int i = 0; i < 2000; i++) begin
        logic rs, ld, en, up;
        logic [7:0] lb;
        rs = (i != 0) && ($urandom_range(0, 99) < 2);
        ld = ($urandom_range(0, 99) < 8);
        en = ($urandom_range(0, 99) < 75);
        up = ($urandom_range(0, 99) < (i < 1000 ? 70 : 30));
        lb = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) lb = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
        @(negedge clk);
        #1;
        reset8 = rs;
        if8.en = en; if8.up = up; if8.load = ld; if8.load_bin = lb;
        mw = 1'b0;
        if (rs) mc = 8'h00;
        else if (ld) mc = lb;
        else if (en && up) begin mw = (mc == 8'hFF); mc = mc + 8'h01; end
        else if (en) begin mw = (mc == 8'h00); mc = mc - 8'h01; end
        if (mw) model_wraps8++;
        @(posedge clk);
        q8.push_back('{b: mc, g: mc ^ (mc >> 1), w: mw});
      end
    end

    repeat (3) @(negedge clk);
    check("queue4_drained", q4.size(), 32'd0);
    check("queue8_drained", q8.size(), 32'd0);
    check("dut8_wrap_count", dut_wraps8, model_wraps8);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
